// File: rtl/pattern_buffer_bank.sv
// Banked field store: combinational core read port plus a stream engine that loads or drains one whole buffer.
// Latency: core and drain reads are combinational, writes land at the clock edge, and done pulses the cycle after the final beat.
// Backpressure: s_in_ready is held high for the whole load, and the drain holds data/last stable while s_out_ready is low.
module pattern_buffer_bank #(
    parameter int D_WIDTH      = 8,
    parameter int BUFP_WIDTH   = 3,
    parameter int FIELDP_WIDTH = 5
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [BUFP_WIDTH+FIELDP_WIDTH-1:0] buf_fieldp,
    input  logic [BUFP_WIDTH+FIELDP_WIDTH-1:0] buf_fieldwp,
    input  logic                               field_write_en,
    input  logic [D_WIDTH-1:0]                 field_in,
    output logic [D_WIDTH-1:0]                 field_out,
    input  logic                               cmd_start,
    input  logic                               cmd_drain,
    input  logic [BUFP_WIDTH-1:0]              cmd_buf,
    input  logic                               s_in_valid,
    input  logic [D_WIDTH-1:0]                 s_in_data,
    output logic                               s_in_ready,
    output logic                               s_out_valid,
    output logic [D_WIDTH-1:0]                 s_out_data,
    output logic                               s_out_last,
    input  logic                               s_out_ready,
    output logic                               busy,
    output logic                               done
);
    localparam int AW     = BUFP_WIDTH + FIELDP_WIDTH;
    localparam int NWORDS = 1 << AW;
    localparam logic [FIELDP_WIDTH-1:0] FMAX = '1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [BUFP_WIDTH-1:0]   cur_buf;
    logic [FIELDP_WIDTH-1:0] cnt;
    logic                    done_q;
    logic [D_WIDTH-1:0]      mem [NWORDS];

    logic start_ok, beat, final_beat, load_wr;

    assign start_ok   = (state == IDLE) && cmd_start;
    assign beat       = ((state == LOAD) && s_in_valid) || ((state == DRAIN) && s_out_ready);
    assign final_beat = beat && (cnt == FMAX);
    // A load beat that coincides with reset is dropped so storage only holds completed beats.
    assign load_wr    = (state == LOAD) && s_in_valid && !reset;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (cmd_start) state_nxt = cmd_drain ? DRAIN : LOAD;
            LOAD, DRAIN: if (final_beat) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_in_ready  = (state == LOAD);
        s_out_valid = (state == DRAIN);
        s_out_last  = (state == DRAIN) && (cnt == FMAX);
        busy        = (state != IDLE);
        done        = done_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_buf <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= final_beat;
            if (start_ok) begin
                cur_buf <= cmd_buf;
                cnt     <= '0;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Core write is issued last so it wins over a same-word load beat.
    always_ff @(posedge clk) begin
        if (load_wr)        mem[{cur_buf, cnt}] <= s_in_data;
        if (field_write_en) mem[buf_fieldwp]    <= field_in;
    end

    assign field_out  = mem[buf_fieldp];
    assign s_out_data = mem[{cur_buf, cnt}];
endmodule

// File: tb/tb_pattern_buffer_bank.sv
module tb_pattern_buffer_bank;
    localparam int NF = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] buf_fieldp, buf_fieldwp;
    logic       field_write_en;
    logic [7:0] field_in, field_out;
    logic       cmd_start, cmd_drain;
    logic [2:0] cmd_buf;
    logic       s_in_valid, s_in_ready;
    logic [7:0] s_in_data;
    logic       s_out_valid, s_out_last, s_out_ready;
    logic [7:0] s_out_data;
    logic       busy, done;

    // Small-geometry instance: 2 buffers x 4 fields x 16 bits
    logic [2:0]  fieldp_6, fieldwp_6;
    logic        we_6;
    logic [15:0] fin_6, fout_6;
    logic        cmd_start_6, cmd_drain_6;
    logic [0:0]  cmd_buf_6;
    logic        in_valid_6, in_ready_6;
    logic [15:0] in_data_6, out_data_6;
    logic        out_valid_6, out_last_6, out_ready_6, busy_6, done_6;

    int total = 0;
    int bad   = 0;
    logic [7:0] ref_mem [256];

    always #5 clk = ~clk;

    pattern_buffer_bank u_dut (
        .clk(clk), .reset(reset), .buf_fieldp(buf_fieldp), .buf_fieldwp(buf_fieldwp),
        .field_write_en(field_write_en), .field_in(field_in), .field_out(field_out),
        .cmd_start(cmd_start), .cmd_drain(cmd_drain), .cmd_buf(cmd_buf),
        .s_in_valid(s_in_valid), .s_in_data(s_in_data), .s_in_ready(s_in_ready),
        .s_out_valid(s_out_valid), .s_out_data(s_out_data), .s_out_last(s_out_last),
        .s_out_ready(s_out_ready), .busy(busy), .done(done)
    );

    pattern_buffer_bank #(.D_WIDTH(16), .BUFP_WIDTH(1), .FIELDP_WIDTH(2)) u_dut6 (
        .clk(clk), .reset(reset), .buf_fieldp(fieldp_6), .buf_fieldwp(fieldwp_6),
        .field_write_en(we_6), .field_in(fin_6), .field_out(fout_6),
        .cmd_start(cmd_start_6), .cmd_drain(cmd_drain_6), .cmd_buf(cmd_buf_6),
        .s_in_valid(in_valid_6), .s_in_data(in_data_6), .s_in_ready(in_ready_6),
        .s_out_valid(out_valid_6), .s_out_data(out_data_6), .s_out_last(out_last_6),
        .s_out_ready(out_ready_6), .busy(busy_6), .done(done_6)
    );

    function automatic int ad(input int b, input int f);
        return b * NF + f;
    endfunction

    // Load a whole buffer; pattern 0 streams i+1, otherwise random data with random valid gaps.
    task automatic do_load(input int b, input int pattern, input int collide, input int disturb);
        int i = 0;
        int cyc = 0;
        logic v;
        logic [7:0] d;
        @(negedge clk);
        cmd_start = 1'b1; cmd_drain = 1'b0; cmd_buf = 3'(b);
        @(negedge clk);
        cmd_start = 1'b0;
        total++;
        if (busy !== 1'b1 || s_in_ready !== 1'b1) begin
            bad++; $display("FAIL load_start buf=%0d busy=%b ready=%b expected 1/1", b, busy, s_in_ready);
        end
        while (i < NF && cyc < 2000) begin
            v = (pattern == 0) || ($urandom_range(0, 3) != 0) || (i == collide);
            d = (pattern == 0) ? 8'(i + 1) : 8'($urandom);
            s_in_valid = v; s_in_data = d;
            field_write_en = 1'b0;
            if (i == collide) begin
                field_write_en = 1'b1; buf_fieldwp = 8'(ad(b, i)); field_in = 8'h3C;
            end
            if (disturb != 0 && i == 3) begin
                cmd_start = 1'b1; cmd_drain = 1'b1; cmd_buf = 3'(b ^ 1);
            end else begin
                cmd_start = 1'b0;
            end
            if (v) begin
                ref_mem[ad(b, i)] = (i == collide) ? 8'h3C : d;
                i++;
            end
            @(negedge clk);
            cyc++;
            total++;
            if (i < NF) begin
                if (busy !== 1'b1 || done !== 1'b0 || s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
                    bad++; $display("FAIL load_mid beat=%0d busy=%b done=%b in_rdy=%b out_vld=%b expected 1/0/1/0",
                                    i, busy, done, s_in_ready, s_out_valid);
                end
            end else if (done !== 1'b1 || busy !== 1'b0 || s_in_ready !== 1'b0) begin
                bad++; $display("FAIL load_done busy=%b done=%b in_rdy=%b expected 0/1/0", busy, done, s_in_ready);
            end
        end
        s_in_valid = 1'b0; field_write_en = 1'b0; cmd_start = 1'b0;
        total++;
        if (cyc >= 2000) begin
            bad++; $display("FAIL load_timeout beats=%0d expected %0d", i, NF);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL load_done_pulse done=%b expected 0", done);
        end
    endtask

    task automatic do_drain(input int b, input int toggle, input int poke);
        int i = 0;
        int cyc = 0;
        logic rdy;
        logic hold = 1'b0;
        logic [7:0] prev = '0;
        @(negedge clk);
        cmd_start = 1'b1; cmd_drain = 1'b1; cmd_buf = 3'(b);
        @(negedge clk);
        cmd_start = 1'b0;
        while (i < NF && cyc < 2000) begin
            total++;
            if (s_out_valid !== 1'b1 || s_out_data !== ref_mem[ad(b, i)] || s_out_last !== (i == NF - 1)) begin
                bad++; $display("FAIL drain_beat idx=%0d vld=%b data=%h last=%b expected 1/%h/%b",
                                i, s_out_valid, s_out_data, s_out_last, ref_mem[ad(b, i)], (i == NF - 1));
            end
            if (hold) begin
                total++;
                if (s_out_data !== prev) begin
                    bad++; $display("FAIL drain_stall_stable idx=%0d data=%h expected %h", i, s_out_data, prev);
                end
            end
            rdy = (toggle != 0) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            s_out_ready = rdy;
            field_write_en = 1'b0;
            hold = !rdy;
            prev = s_out_data;
            if (!rdy && i == poke) begin
                field_write_en = 1'b1; buf_fieldwp = 8'(ad(b, i)); field_in = 8'($urandom);
                ref_mem[ad(b, i)] = field_in;
                hold = 1'b0;
            end
            if (rdy) i++;
            @(negedge clk);
            cyc++;
        end
        s_out_ready = 1'b0; field_write_en = 1'b0;
        total++;
        if (cyc >= 2000 || done !== 1'b1 || busy !== 1'b0 || s_out_valid !== 1'b0 || s_out_last !== 1'b0) begin
            bad++; $display("FAIL drain_done cyc=%0d done=%b busy=%b vld=%b last=%b expected 1/0/0/0",
                            cyc, done, busy, s_out_valid, s_out_last);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL drain_done_pulse done=%b expected 0", done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || s_in_ready !== 1'b0 || s_out_valid !== 1'b0 || s_out_last !== 1'b0) begin
            bad++; $display("FAIL reset_state busy=%b done=%b in_rdy=%b out_vld=%b last=%b expected all 0",
                            busy, done, s_in_ready, s_out_valid, s_out_last);
        end
        reset = 1'b0;
    endtask

    task automatic test_core_port();
        int wa;
        int ra;
        @(negedge clk);
        buf_fieldwp = 8'(ad(3, 7)); buf_fieldp = 8'(ad(3, 7)); field_in = 8'hA5; field_write_en = 1'b1;
        #1;
        total++;
        if (field_out !== ref_mem[ad(3, 7)]) begin
            bad++; $display("FAIL core_same_cycle_old data=%h expected %h", field_out, ref_mem[ad(3, 7)]);
        end
        ref_mem[ad(3, 7)] = 8'hA5;
        @(negedge clk);
        field_write_en = 1'b0;
        #1;
        total++;
        if (field_out !== 8'hA5) begin
            bad++; $display("FAIL core_readback data=%h expected a5", field_out);
        end
        wa = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            ra = ($urandom_range(0, 1) != 0) ? wa : int'($urandom_range(0, 255));
            wa = int'($urandom_range(0, 255));
            buf_fieldwp = 8'(wa); buf_fieldp = 8'(ra); field_in = 8'($urandom);
            field_write_en = 1'($urandom_range(0, 1));
            #1;
            total++;
            if (field_out !== ref_mem[ra]) begin
                bad++; $display("FAIL core_random addr=%h data=%h expected %h", ra, field_out, ref_mem[ra]);
            end
            if (field_write_en) ref_mem[wa] = field_in;
        end
        @(negedge clk);
        field_write_en = 1'b0;
    endtask

    task automatic test_load_read(input int b, input int pattern, input int collide, input int disturb);
        do_load(b, pattern, collide, disturb);
        for (int f = 0; f < NF; f++) begin
            buf_fieldp = 8'(ad(b, f));
            #1;
            total++;
            if (field_out !== ref_mem[ad(b, f)]) begin
                bad++; $display("FAIL load_readback buf=%0d field=%0d data=%h expected %h",
                                b, f, field_out, ref_mem[ad(b, f)]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        test_load_read(4, 1, -1, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL ignored_cmd_after done=%b busy=%b expected 0/0", done, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cmd_start = 1'b1; cmd_drain = 1'b0; cmd_buf = 3'd1;
        @(negedge clk);
        cmd_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_in_valid = 1'b1; s_in_data = 8'($urandom);
            ref_mem[ad(1, i)] = s_in_data;
            @(negedge clk);
        end
        s_in_data = 8'($urandom);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || s_in_ready !== 1'b0 || done !== 1'b0 || s_out_valid !== 1'b0 || s_out_last !== 1'b0) begin
            bad++; $display("FAIL reset_mid busy=%b in_rdy=%b done=%b out_vld=%b last=%b expected all 0",
                            busy, s_in_ready, done, s_out_valid, s_out_last);
        end
        reset = 1'b0; s_in_valid = 1'b0;
        for (int f = 0; f < 10; f++) begin
            buf_fieldp = 8'(ad(1, f));
            #1;
            total++;
            if (field_out !== ref_mem[ad(1, f)]) begin
                bad++; $display("FAIL reset_mid_keep field=%0d data=%h expected %h", f, field_out, ref_mem[ad(1, f)]);
            end
        end
    endtask

    task automatic test_small();
        @(negedge clk);
        cmd_start_6 = 1'b1; cmd_drain_6 = 1'b0; cmd_buf_6 = 1'b1;
        @(negedge clk);
        cmd_start_6 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid_6 = 1'b1; in_data_6 = 16'hBEEF + 16'(k);
            @(negedge clk);
        end
        in_valid_6 = 1'b0;
        fieldp_6 = 3'b110;
        #1;
        total++;
        if (done_6 !== 1'b1 || busy_6 !== 1'b0 || fout_6 !== 16'hBEF1) begin
            bad++; $display("FAIL small_load done=%b busy=%b f2=%h expected 1/0/bef1", done_6, busy_6, fout_6);
        end
        @(negedge clk);
        cmd_start_6 = 1'b1; cmd_drain_6 = 1'b1;
        @(negedge clk);
        cmd_start_6 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_valid_6 !== 1'b1 || out_data_6 !== 16'hBEEF + 16'(k) || out_last_6 !== (k == 3)) begin
                bad++; $display("FAIL small_drain idx=%0d vld=%b data=%h last=%b expected 1/%h/%b",
                                k, out_valid_6, out_data_6, out_last_6, 16'hBEEF + 16'(k), (k == 3));
            end
            out_ready_6 = 1'b1;
            @(negedge clk);
        end
        out_ready_6 = 1'b0;
        total++;
        if (done_6 !== 1'b1 || busy_6 !== 1'b0) begin
            bad++; $display("FAIL small_drain_done done=%b busy=%b expected 1/0", done_6, busy_6);
        end
    endtask

    initial begin
        reset = 1'b1;
        buf_fieldp = '0; buf_fieldwp = '0; field_write_en = 1'b0; field_in = '0;
        cmd_start = 1'b0; cmd_drain = 1'b0; cmd_buf = '0;
        s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
        fieldp_6 = '0; fieldwp_6 = '0; we_6 = 1'b0; fin_6 = '0;
        cmd_start_6 = 1'b0; cmd_drain_6 = 1'b0; cmd_buf_6 = '0;
        in_valid_6 = 1'b0; in_data_6 = '0; out_ready_6 = 1'b0;

        test_reset();
        test_core_port();
        test_load_read(2, 0, -1, 0);
        do_drain(2, 1, -1);
        test_load_read(5, 1, 4, 0);
        test_busy_ignore();
        do_drain(5, 0, 7);
        test_reset_mid();
        test_small();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
